// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives EN/flush of the IF/ID, ID/EX, EX/MEM, MEM/WB pipe registers.
// Optional perf counters (stall_cycles, flush_cycles) are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       xm_dREN,
    input  logic       xm_dWEN,
    input  logic       xm_halt,
    input  logic       dx_dREN,
    input  logic [4:0] dx_wsel,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rt,
    input  logic       ex_redirect,
    output logic       pc_en,
    output logic       fd_en,
    output logic       fd_flush,
    output logic       dx_en,
    output logic       dx_flush,
    output logic       xm_en,
    output logic       mw_en,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

    if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3 || CNT_W < 1) begin : g_bad_params
        $error("pipe_hazard_ctrl: LOAD_BUBBLES must be 1..3 and CNT_W positive");
    end

    state_t     state_r, next_state_s;
    logic [1:0] bcnt_r, next_bcnt_s;
    logic       dmem_wait_s, imem_wait_s, lu_s;

    // Hazard detection; register 0 can never be a load-use source
    always_comb begin
        dmem_wait_s = (xm_dREN | xm_dWEN) & ~dhit;
        imem_wait_s = ~ihit & ~(xm_dREN | xm_dWEN);
        lu_s        = dx_dREN & (dx_wsel != 5'd0) &
                      ((dx_wsel == fd_rs) | (fd_uses_rt & (dx_wsel == fd_rt)));
    end

    // Next-state and pipe-control outputs, in strict priority order
    always_comb begin
        next_state_s = state_r;
        next_bcnt_s  = bcnt_r;
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        fd_flush     = 1'b0;
        dx_en        = 1'b1;
        dx_flush     = 1'b0;
        xm_en        = 1'b1;
        mw_en        = 1'b1;
        halted       = 1'b0;
        if (RST) begin
            {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b00000;
        end else begin
            case (state_r)
                ST_HALTED: begin
                    {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b00000;
                    halted = 1'b1;
                end
                ST_RUN, ST_LDSTALL: begin
                    if (dmem_wait_s || imem_wait_s) begin
                        {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b00000;
                    end else if (ex_redirect) begin
                        // The squashed ID instruction makes any coincident load-use moot
                        fd_flush     = 1'b1;
                        dx_flush     = 1'b1;
                        next_state_s = ST_RUN;
                        next_bcnt_s  = 2'd0;
                    end else if (state_r == ST_RUN && lu_s) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        dx_flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            next_state_s = ST_LDSTALL;
                            next_bcnt_s  = BCNT_INIT;
                        end else begin
                            next_state_s = ST_RUN;
                        end
                    end else if (state_r == ST_LDSTALL) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        dx_flush = 1'b1;
                        if (bcnt_r <= 2'd1) begin
                            next_state_s = ST_RUN;
                            next_bcnt_s  = 2'd0;
                        end else begin
                            next_bcnt_s = bcnt_r - 2'd1;
                        end
                    end else begin
                        next_state_s = ST_RUN;
                    end
                    // A halt leaves MEM on the same edge MEM/WB captures it
                    if (xm_halt && xm_en) begin
                        next_state_s = ST_HALTED;
                        next_bcnt_s  = 2'd0;
                    end else begin
                        next_bcnt_s = next_bcnt_s;
                    end
                end
                default: begin
                    {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b00000;
                    next_state_s = ST_RUN;
                    next_bcnt_s  = 2'd0;
                end
            endcase
        end
    end

    // State and bubble counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_RUN;
            bcnt_r  <= 2'd0;
        end else begin
            state_r <= next_state_s;
            bcnt_r  <= next_bcnt_s;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    // Saturating perf counters, frozen once halted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_HALTED) begin
            if (!pc_en && (stall_cnt_r != {CNT_W{1'b1}}))
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (fd_flush && (flush_cnt_r != {CNT_W{1'b1}}))
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_cycles = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl, run with LOAD_BUBBLES=1 and LOAD_BUBBLES=3 side by side.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst, ihit, dhit, xr, xw, xh, dr;
        logic [4:0] wsel, rs, rt;
        logic       urt, red;
    } in_t;

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e3;
    } exp_t;

    // {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, mw_en, halted}
    localparam logic [7:0] N = 8'b1101_0110;
    localparam logic [7:0] B = 8'b0001_1110;
    localparam logic [7:0] F = 8'b1111_1110;
    localparam logic [7:0] H = 8'b0000_0001;
    localparam logic [7:0] Z = 8'b0000_0000;

    logic CLK, RST, ihit, dhit, xm_dREN, xm_dWEN, xm_halt, dx_dREN, fd_uses_rt, ex_redirect;
    logic [4:0] dx_wsel, fd_rs, fd_rt;
    logic pc_en1, fd_en1, fd_flush1, dx_en1, dx_flush1, xm_en1, mw_en1, halted1;
    logic pc_en3, fd_en3, fd_flush3, dx_en3, dx_flush3, xm_en3, mw_en3, halted3;
    logic [7:0] o1, o3;
    int n_vec = 0;
    int n_mis = 0;
    exp_t sb[$];

`ifdef HAZARD_PERF_EN
    logic [31:0] stall1, flush1, stall3, flush3;
`endif

    assign o1 = {pc_en1, fd_en1, fd_flush1, dx_en1, dx_flush1, xm_en1, mw_en1, halted1};
    assign o3 = {pc_en3, fd_en3, fd_flush3, dx_en3, dx_flush3, xm_en3, mw_en3, halted3};

    pipe_hazard_ctrl #(.LOAD_BUBBLES(1)) dut1 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .xm_dREN(xm_dREN), .xm_dWEN(xm_dWEN),
        .xm_halt(xm_halt), .dx_dREN(dx_dREN), .dx_wsel(dx_wsel), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .ex_redirect(ex_redirect), .pc_en(pc_en1), .fd_en(fd_en1),
        .fd_flush(fd_flush1), .dx_en(dx_en1), .dx_flush(dx_flush1), .xm_en(xm_en1),
        .mw_en(mw_en1), .halted(halted1)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall1), .flush_cycles(flush1)
`endif
    );

    pipe_hazard_ctrl #(.LOAD_BUBBLES(3)) dut3 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .xm_dREN(xm_dREN), .xm_dWEN(xm_dWEN),
        .xm_halt(xm_halt), .dx_dREN(dx_dREN), .dx_wsel(dx_wsel), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .ex_redirect(ex_redirect), .pc_en(pc_en3), .fd_en(fd_en3),
        .fd_flush(fd_flush3), .dx_en(dx_en3), .dx_flush(dx_flush3), .xm_en(xm_en3),
        .mw_en(mw_en3), .halted(halted3)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall3), .flush_cycles(flush3)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic in_t mk(input logic r, ih, dh, xr, xw, xh, dr,
                               input logic [4:0] ws, rs, rt, input logic urt, red);
        in_t v;
        v = '{rst: r, ihit: ih, dhit: dh, xr: xr, xw: xw, xh: xh, dr: dr,
              wsel: ws, rs: rs, rt: rt, urt: urt, red: red};
        return v;
    endfunction

    task automatic apply(input in_t v);
        RST = v.rst; ihit = v.ihit; dhit = v.dhit; xm_dREN = v.xr; xm_dWEN = v.xw;
        xm_halt = v.xh; dx_dREN = v.dr; dx_wsel = v.wsel; fd_rs = v.rs; fd_rt = v.rt;
        fd_uses_rt = v.urt; ex_redirect = v.red;
    endtask

    task automatic push(input logic [7:0] e1, input logic [7:0] e3);
        exp_t t;
        t.e1 = e1;
        t.e3 = e3;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        in_t st[$];
        exp_t t;
        st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(Z, Z);
        st.push_back(mk(1, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1)); push(Z, Z);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL reset[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_normal();
        in_t st[$];
        exp_t t;
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd3, 5'd4, 5'd5, 1, 0)); push(N, N);
        st.push_back(mk(0, 1, 1, 0, 1, 0, 0, 5'd7, 5'd7, 5'd7, 1, 0)); push(N, N);
        st.push_back(mk(0, 1, 1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0)); push(N, N);
        st.push_back(mk(0, 0, 1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0)); push(N, N);
        st.push_back(mk(0, 0, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0)); push(Z, Z);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd9, 5'd8, 0, 0)); push(N, N);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL normal[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        in_t st[$];
        exp_t t;
        st.push_back(mk(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0)); push(B, B);
        st.push_back(mk(0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0)); push(N, B);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0)); push(N, B);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0)); push(N, N);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL load_use[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_rt_freeze();
        in_t st[$];
        exp_t t;
        st.push_back(mk(0, 1, 1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0)); push(B, B);
        st.push_back(mk(0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd3, 5'd9, 1, 0)); push(N, B);
        st.push_back(mk(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd3, 5'd9, 1, 0)); push(Z, Z);
        st.push_back(mk(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd3, 5'd9, 1, 0)); push(Z, Z);
        st.push_back(mk(0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd3, 5'd9, 1, 0)); push(N, B);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd3, 5'd9, 1, 0)); push(N, N);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL rt_freeze[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_redirect();
        in_t st[$];
        exp_t t;
        st.push_back(mk(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1)); push(F, F);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0)); push(N, N);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0)); push(B, B);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 1)); push(F, F);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 0, 0)); push(N, N);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL redirect[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_dmem_redirect();
        in_t st[$];
        exp_t t;
        for (int k = 0; k < 4; k++) begin
            st.push_back(mk(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1)); push(Z, Z);
        end
        st.push_back(mk(0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1)); push(F, F);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(N, N);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL dmem_redirect[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        in_t st[$];
        exp_t t;
        st.push_back(mk(0, 1, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(Z, Z);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(N, N);
        st.push_back(mk(0, 1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(N, N);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(H, H);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1)); push(H, H);
        st.push_back(mk(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(H, H);
        st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(Z, Z);
        st.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0)); push(N, N);
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge CLK);
            t = sb.pop_front();
            n_vec++;
            if ({o1, o3} !== {t.e1, t.e3}) begin
                n_mis++;
                $display("FAIL halt[%0d]: lb1=%b lb3=%b want %b %b", i, o1, o3, t.e1, t.e3);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        apply(mk(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0));
        test_reset();
        test_normal();
        test_load_use();
        test_rt_freeze();
        test_redirect();
        test_dmem_redirect();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit that drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers. It is the controlling end of their EN/flush interface.
- Detects load-use hazards, instruction/data memory wait, taken branches/jumps resolved in EX, and halt retirement.
- Sequences stalls and bubbles with a registered state machine; the datapath pipe registers only obey EN/flush.

Parameters:
- LOAD_BUBBLES, 1, number of bubble cycles inserted on a load-use hazard (1..3).
- CNT_W, 32, width of the perf counters (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- xm_dREN  in  1  load in MEM stage.
- xm_dWEN  in  1  store in MEM stage.
- xm_halt  in  1  halt instruction in MEM stage.
- dx_dREN  in  1  load in EX stage.
- dx_wsel  in  5  destination register of EX-stage instruction.
- fd_rs  in  5  rs field of ID-stage instruction.
- fd_rt  in  5  rt field of ID-stage instruction.
- fd_uses_rt  in  1  ID-stage instruction reads rt.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- pc_en  out  1  PC update enable.
- fd_en  out  1  IF/ID enable.
- fd_flush  out  1  IF/ID flush.
- dx_en  out  1  ID/EX enable.
- dx_flush  out  1  ID/EX flush (bubble).
- xm_en  out  1  EX/MEM enable.
- mw_en  out  1  MEM/WB enable.
- halted  out  1  sticky halt indicator.

Behaviour:
- States: RUN, LDSTALL, HALTED. State and the bubble counter bcnt (2 bits) are registered; outputs are combinational from state and inputs.
- Reset (RST high, asynchronous): state=RUN, bcnt=0. While RST is high, all *_en=0, fd_flush=0, dx_flush=0, halted=0. Reset mid-stall or in HALTED returns to RUN with no residual bubble.
- dmem_wait = (xm_dREN|xm_dWEN) & ~dhit.
- imem_wait = ~ihit & ~(xm_dREN|xm_dWEN).
- lu = dx_dREN & (dx_wsel!=0) & ((dx_wsel==fd_rs) | (fd_uses_rt & dx_wsel==fd_rt)).
- Output priority, highest first, evaluated every cycle:
  1. HALTED: all en=0, flushes=0, halted=1. The state is left only by reset.
  2. dmem_wait or imem_wait: all en=0, flushes=0 (full freeze). State and bcnt are held.
  3. ex_redirect: all en=1, fd_flush=1, dx_flush=1. Any load-use in the same cycle is discarded, since the ID instruction is squashed. If in LDSTALL, go to RUN and clear bcnt.
  4. RUN & lu: pc_en=0, fd_en=0, dx_en=1, dx_flush=1, xm_en=mw_en=1. If LOAD_BUBBLES>1, go to LDSTALL with bcnt=LOAD_BUBBLES-1; otherwise stay in RUN.
  5. LDSTALL: same outputs as item 4; decrement bcnt. When bcnt reaches 1, return to RUN next cycle.
  6. Otherwise: all en=1, flushes=0.
- Halt: when xm_halt=1 and xm_en=1 in a cycle, go to HALTED at the next edge. The MEM/WB pipe captures the halt on that same edge.
- Flush always dominates enable at the pipe register. The flush outputs are asserted only in cycles where the corresponding en=1 or the pipe is advancing.
- Register 0 is never a hazard source.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs stall_cycles [CNT_W-1:0] and flush_cycles [CNT_W-1:0]:
  - stall_cycles increments on every cycle with pc_en=0 and state!=HALTED.
  - flush_cycles increments on every cycle with fd_flush=1.
  - Both reset to 0, saturate at all-ones, and freeze in HALTED.
- When undefined, neither port nor counter exists; remaining behaviour is identical.

Test Plan:
- Reset then ihit=1, no hazards -> all en=1, flushes=0, halted=0 every cycle.
- dx_dREN=1, dx_wsel=8, fd_rs=8, LOAD_BUBBLES=1 -> exactly one cycle of pc_en=fd_en=0 and dx_flush=1, then normal flow. With dx_wsel=0 -> no stall.
- LOAD_BUBBLES=3, load-use on rt (fd_uses_rt=1) -> three consecutive bubble cycles. Inserting dhit=0 for 2 cycles mid-sequence -> full freeze, bubble count resumes at the remaining value.
- ex_redirect=1 coincident with lu=1 -> fd_flush=dx_flush=1, pc_en=1 for one cycle, no load-use bubble follows.
- xm_dREN=1, dhit=0 for 4 cycles, with ex_redirect=1 held -> 4 cycles all en=0 and no flush; flush occurs on the cycle dhit=1.
- xm_halt=1 -> halted=1 from the next cycle, all en=0 thereafter. Under HAZARD_PERF_EN, counters stop. RST pulse -> state RUN, counters 0.
